// File: rtl/scroll_feeder.sv
// rtl/scroll_feeder.sv - message buffer and sliding 4-nibble window feeding the scroll display register
// Optional feature macro: SCROLL_DIR_EN (adds in_DIR for right-scroll steps)
module scroll_feeder #(
    parameter int MSG_DEPTH = 16,
    parameter int PRESCALE  = 25000000
) (
    input  logic        in_CLK,
    input  logic        in_RST,
    input  logic        in_WR_EN,
    input  logic [3:0]  in_WR_ADDR,
    input  logic [3:0]  in_WR_DATA,
    input  logic [4:0]  in_LEN,
    input  logic        in_RUN,
`ifdef SCROLL_DIR_EN
    input  logic        in_DIR,
`endif
    output logic [15:0] out_D,
    output logic        out_EN,
    output logic [3:0]  out_POS
);

    localparam int AW = $clog2(MSG_DEPTH);
    localparam int PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);
    localparam logic [4:0]    DEPTH5  = 5'(MSG_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t        state_q;
    logic [3:0]    msg_q [MSG_DEPTH];
    logic [15:0]   out_d_q;
    logic          out_en_q;
    logic [3:0]    pos_q;
    logic [PW-1:0] presc_q;
    logic [1:0]    fill_cnt_q;
    logic [11:0]   shadow_q;
    logic [4:0]    len_q;

    logic [4:0]    len_clamp_d;
    logic [4:0]    fwd_sum_d;
    logic [4:0]    fwd_idx_d;
    logic [4:0]    pos_inc_d;
    logic [3:0]    fill_nib_d;
    logic [15:0]   step_win_d;
    logic [3:0]    step_pos_d;
`ifdef SCROLL_DIR_EN
    logic [4:0]    bwd_idx_d;
`endif

    // Effective length, wrap-aware neighbour indices and the next window for a step
    always_comb begin
        len_clamp_d = in_LEN;
        if (in_LEN < 5'd4) begin
            len_clamp_d = 5'd4;
        end else if (in_LEN > DEPTH5) begin
            len_clamp_d = DEPTH5;
        end

        // pos < L and L >= 4, so pos+4 < 2L and one subtraction suffices
        fwd_sum_d  = {1'b0, pos_q} + 5'd4;
        fwd_idx_d  = (fwd_sum_d >= len_q) ? (fwd_sum_d - len_q) : fwd_sum_d;
        pos_inc_d  = {1'b0, pos_q} + 5'd1;
        fill_nib_d = msg_q[AW'(fill_cnt_q)];

        step_win_d = {out_d_q[11:0], msg_q[fwd_idx_d[AW-1:0]]};
        step_pos_d = (pos_inc_d == len_q) ? 4'd0 : pos_inc_d[3:0];
`ifdef SCROLL_DIR_EN
        bwd_idx_d = (pos_q == 4'd0) ? (len_q - 5'd1) : ({1'b0, pos_q} - 5'd1);
        if (in_DIR) begin
            step_win_d = {msg_q[bwd_idx_d[AW-1:0]], out_d_q[15:4]};
            step_pos_d = bwd_idx_d[3:0];
        end
`endif
    end

    // Message buffer: one write per cycle in any state; reads elsewhere see the old value
    always_ff @(posedge in_CLK) begin
        if (in_RST) begin
            for (int i = 0; i < MSG_DEPTH; i++) begin
                msg_q[i] <= 4'd0;
            end
        end else if (in_WR_EN) begin
            msg_q[in_WR_ADDR[AW-1:0]] <= in_WR_DATA;
        end
    end

    // Scroll FSM: fill the first window, then step once per prescaler period
    always_ff @(posedge in_CLK) begin
        if (in_RST) begin
            state_q    <= IDLE;
            out_d_q    <= 16'd0;
            out_en_q   <= 1'b0;
            pos_q      <= 4'd0;
            presc_q    <= '0;
            fill_cnt_q <= 2'd0;
            shadow_q   <= 12'd0;
            len_q      <= 5'd4;
        end else begin
            out_en_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_RUN) begin
                        state_q    <= FILL;
                        fill_cnt_q <= 2'd0;
                        pos_q      <= 4'd0;
                        presc_q    <= '0;
                        len_q      <= len_clamp_d;
                    end
                end
                FILL: begin
                    if (!in_RUN) begin
                        state_q <= IDLE;
                    end else begin
                        shadow_q   <= {shadow_q[7:0], fill_nib_d};
                        fill_cnt_q <= fill_cnt_q + 2'd1;
                        if (fill_cnt_q == 2'd3) begin
                            out_d_q  <= {shadow_q, fill_nib_d};
                            pos_q    <= 4'd0;
                            out_en_q <= 1'b1;
                            state_q  <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (!in_RUN) begin
                        state_q <= IDLE;
                    end else if (presc_q == PS_LAST) begin
                        presc_q  <= '0;
                        out_d_q  <= step_win_d;
                        pos_q    <= step_pos_d;
                        out_en_q <= 1'b1;
                    end else begin
                        presc_q <= presc_q + PW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign out_D   = out_d_q;
    assign out_EN  = out_en_q;
    assign out_POS = pos_q;

endmodule
